dac_stream_tx: RTL
==================

Name: dac_stream_tx

Overview:
- Transmit-side counterpart to the SAR ADC path: accepts 8-bit samples over a valid/ready stream and buffers them in a FIFO.
- Plays the samples out on the 8-bit parallel R-2R DAC port at a programmable sample rate.
- Sits between a sample source (pattern generator or loopback of binaryOut) and the GPIO DAC pins, in the same clock domain as the ADC.

Parameters:
- DATA_W, 8, sample width and DAC port width.
- DEPTH, 16, FIFO entries; power of two, minimum 4.
- DIV_W, 16, width of the sample-rate divider.

Ports:
- DAC_Clk  input  1  single system clock; all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = play out samples, 0 = idle.
- rateDiv  input  DIV_W  sample period minus one, in DAC_Clk cycles.
- sampleIn  input  DATA_W  write data.
- sampleValid  input  1  write request.
- sampleReady  output  1  FIFO can accept a write.
- underrunClr  input  1  clears the sticky underrun flag.
- dacOut  output  DATA_W  registered value driven to the R-2R ladder.
- sampleStrobe  output  1  one-cycle pulse in the cycle dacOut updates.
- underrun  output  1  sticky flag: a sample tick found the FIFO empty.
- fifoLevel  output  log2(DEPTH)+1  current occupancy.

Behaviour:
- Reset values:
  - dacOut = 8'h80 (midscale); sampleStrobe = 0; underrun = 0; fifoLevel = 0.
  - sampleReady = 1; FIFO empty; divider count = 0; state = IDLE.
- Write side:
  - A write occurs when sampleValid && sampleReady.
  - sampleReady = (fifoLevel != DEPTH), driven combinationally from registered level.
  - Writes are accepted in every state, including IDLE.
- FIFO:
  - Circular buffer with read and write pointers of log2(DEPTH) bits plus a level counter.
  - Pointers wrap from DEPTH-1 to 0.
  - A simultaneous push and pop leaves level unchanged.
  - A write while full is impossible (ready is low).
- Divider:
  - Down-counter reloaded from rateDiv on each tick; a tick occurs when count == 0.
  - Sample period = rateDiv+1 cycles; rateDiv = 0 gives a tick every cycle.
  - rateDiv is sampled only at reload; changes mid-period take effect next period.
  - The counter is held at 0 outside RUN.
- States:
  - IDLE: dacOut holds its last value, no ticks. Goes to PRIME when enable = 1.
  - PRIME: waits for fifoLevel >= DEPTH/2, then goes to RUN. The first tick occurs the cycle after entering RUN, because the count is 0.
  - RUN, tick with FIFO non-empty: pop the head; dacOut takes the popped value on the next edge; sampleStrobe = 1 that cycle.
  - RUN, tick with FIFO empty: dacOut holds, no strobe, underrun set. State stays RUN; playback resumes on the first tick after data arrives.
  - enable = 0 in any state: go to IDLE next cycle. FIFO contents are retained and dacOut holds.
- Latency: in steady RUN, one sample per rateDiv+1 cycles. With an empty FIFO, the first dacOut update is 2 cycles after the DEPTH/2-th accepted write.
- underrun:
  - Set on an empty tick; cleared only by underrunClr or Reset.
  - Set wins over a simultaneous clear.
- Reset mid-operation: everything returns to reset values on the next edge, FIFO is flushed, and any in-flight write in that cycle is dropped.

Optional Feature:
- Macro SIGMA_DELTA_OUT_EN.
- Defined:
  - Adds output port sdOut (1 bit) and a DATA_W+1-bit accumulator, reset to 0.
  - Every cycle, acc <= {1'b0, acc[DATA_W-1:0]} + dacOut, and sdOut = acc[DATA_W], registered.
  - This gives first-order 1-bit PDM of dacOut for a single-pin RC DAC.
- Undefined: port and accumulator are absent; behaviour is otherwise identical.

Test Plan:
- Reset then idle → dacOut = 0x80, sampleReady = 1, fifoLevel = 0, no sampleStrobe over 100 cycles.
- Write 0x00..0x0F, enable = 1, rateDiv = 3 → PRIME exits at level 8; dacOut steps 0x00,0x01,... every 4 cycles; strobe is one cycle wide; full sequence with no loss.
- Write 16 samples with enable = 0 → sampleReady falls after the 16th write; a 17th valid is not accepted; level = 16.
- Play 8 samples at rateDiv = 0 with no refill → after the 8th strobe, underrun = 1 and dacOut holds the last value. Write 0xAA → it appears on the next tick. underrunClr together with another empty tick → underrun stays 1.
- Assert Reset mid-RUN with level = 5 → next cycle dacOut = 0x80, level = 0, state IDLE, underrun = 0.
- With SIGMA_DELTA_OUT_EN and dacOut = 0x40 held → sdOut duty is exactly 64/256 over any 256-cycle window.

Source files
------------

// File: rtl/dac_stream_tx.sv
// Sample stream to R-2R DAC: FIFO buffer, rate divider and playout FSM.
// Optional first-order PDM output on sdOut when SIGMA_DELTA_OUT_EN is defined.
//
// state | meaning
// IDLE  | no ticks, dacOut holds, writes still accepted
// PRIME | waiting for the FIFO to reach half full
// RUN   | divider running, one pop per tick
module dac_stream_tx #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int DIV_W  = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LVL_W = AW + 1
) (
    input  logic              DAC_Clk,
    input  logic              Reset,
    input  logic              enable,
    input  logic [DIV_W-1:0]  rateDiv,
    input  logic [DATA_W-1:0] sampleIn,
    input  logic              sampleValid,
    output logic              sampleReady,
    input  logic              underrunClr,
    output logic [DATA_W-1:0] dacOut,
    output logic              sampleStrobe,
    output logic              underrun,
`ifdef SIGMA_DELTA_OUT_EN
    output logic              sdOut,
`endif
    output logic [LVL_W-1:0]  fifoLevel
);

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]  HALF_LVL = LVL_W'(DEPTH / 2);
    localparam logic [DATA_W-1:0] MIDSCALE = DATA_W'(1) << (DATA_W - 1);

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [DATA_W-1:0]   dac_q, dac_d;
    logic                strobe_q, strobe_d;
    logic                underrun_q, underrun_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
    logic                push, pop, tick, empty_tick;

    assign sampleReady  = (level_q != FULL_LVL);
    assign push         = sampleValid && sampleReady;
    assign tick         = (state_q == RUN) && (cnt_q == '0);
    assign pop          = tick && (level_q != '0);
    assign empty_tick   = tick && (level_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            IDLE:  if (enable) state_d = PRIME;
            PRIME: if (level_q >= HALF_LVL) state_d = RUN;
            RUN:   cnt_d = (cnt_q == '0) ? rateDiv : cnt_q - DIV_W'(1);
            default: state_d = IDLE;
        endcase
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        dac_d    = dac_q;
        strobe_d = pop;
        if (push) begin
            mem_d[wr_ptr_q] = sampleIn;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            dac_d    = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop)
            level_d = level_q + LVL_W'(1);
        else if (pop && !push)
            level_d = level_q - LVL_W'(1);
        // a simultaneous set beats the clear
        underrun_d = empty_tick ? 1'b1 : (underrunClr ? 1'b0 : underrun_q);
    end

    always_ff @(posedge DAC_Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            dac_q      <= MIDSCALE;
            strobe_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            dac_q      <= dac_d;
            strobe_q   <= strobe_d;
            underrun_q <= underrun_d;
        end
    end

    // storage needs no reset; pointers and level define validity
    always_ff @(posedge DAC_Clk) begin
        mem_q <= mem_d;
    end

    assign dacOut       = dac_q;
    assign sampleStrobe = strobe_q;
    assign underrun     = underrun_q;
    assign fifoLevel    = level_q;

`ifdef SIGMA_DELTA_OUT_EN
    logic [DATA_W:0] acc_q, acc_d;

    always_comb begin
        acc_d = {1'b0, acc_q[DATA_W-1:0]} + {1'b0, dac_q};
    end

    always_ff @(posedge DAC_Clk) begin
        if (Reset) acc_q <= '0;
        else       acc_q <= acc_d;
    end

    assign sdOut = acc_q[DATA_W];
`endif

endmodule
